sram_wr_sched: RTL and testbench
================================

Name: sram_wr_sched

Overview:
- Sits between the SPI instruction decoder and the single-port frame SRAM.
- Turns decoder requests (pixel write, window set, clear) into SRAM writes at a cursor that walks the CASET/RASET window.
- Shares the SRAM port with the HDMI scan-out reader; the reader always has priority.
- A small write FIFO absorbs pixel bursts while the reader holds the port.

Parameters:
- H_SIZE, 160, panel width in pixels.
- V_SIZE, 128, panel height in pixels.
- ADDR_W, 15, SRAM word address width; must satisfy 2^ADDR_W >= H_SIZE*V_SIZE.
- FIFO_DEPTH, 4, write FIFO entries; power of two.
- CLR_DATA, 16'h0000, pixel value written by a clear.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pixel_data  in  16  RGB565 pixel from the decoder.
- i_col_addr  in  32  XS[31:16], XE[15:0].
- i_row_addr  in  32  YS[31:16], YE[15:0].
- i_sram_write_req  in  1  one-cycle pulse: write i_pixel_data at the cursor.
- i_sram_waddr_set_req  in  1  one-cycle pulse: reload the cursor from the window.
- i_sram_clr_req  in  1  one-cycle pulse: fill the whole frame with CLR_DATA.
- i_rd_req  in  1  scan-out read request.
- i_rd_addr  in  ADDR_W  scan-out read address.
- o_rd_data  out  16  read data.
- o_rd_valid  out  1  o_rd_data valid.
- o_mem_en  out  1  SRAM enable.
- o_mem_we  out  1  SRAM write enable.
- o_mem_addr  out  ADDR_W  SRAM address.
- o_mem_wdata  out  16  SRAM write data.
- i_mem_rdata  in  16  SRAM read data; 1-cycle latency after o_mem_en with ~o_mem_we.
- o_busy  out  1  high while a clear is running or the FIFO is non-empty.
- o_ovf  out  1  one-cycle pulse when a pixel is dropped because the FIFO is full.

Behaviour:
- Reset values:
  - All outputs 0.
  - Cursor x=0, y=0, row_base=0.
  - Window XS=0, XE=H_SIZE-1, YS=0, YE=V_SIZE-1.
  - FIFO empty; FSM in IDLE.
- SRAM port control is combinational from the registered state and i_rd_req.
- Port priority each cycle: read > clear > FIFO drain.
  - If i_rd_req=1: o_mem_en=1, o_mem_we=0, o_mem_addr=i_rd_addr.
  - o_rd_valid=1 exactly one cycle later, with o_rd_data=i_mem_rdata.
- Window set (waddr_set_req):
  - Latch XS/XE/YS/YE; cursor x=XS, y=YS; row_base=YS*H_SIZE (constant multiply).
  - Takes effect the next cycle.
  - If it coincides with write_req, the set applies first and the pixel lands at (XS,YS).
- Pixel accept (write_req):
  - Push {row_base+x, i_pixel_data} into the FIFO, then advance the cursor.
  - x==XE: x=XS, y+1, row_base+=H_SIZE.
  - x==XE and y==YE: y=YS, row_base=YS*H_SIZE.
  - Otherwise x+1.
  - If XS>XE, x stays at XS and y advances every pixel; YS>YE is handled symmetrically.
  - Pixels with x>=H_SIZE or y>=V_SIZE are not pushed, but the cursor still advances.
  - FIFO full at accept: pixel dropped, o_ovf pulses, cursor still advances.
- FIFO drain: when i_rd_req=0, FSM in IDLE and FIFO non-empty, pop one entry per cycle to the SRAM (o_mem_en=1, o_mem_we=1).
- FSM states:
  - IDLE: drains the FIFO.
  - CLEAR: clr_cnt sweeps 0..H_SIZE*V_SIZE-1, writing CLR_DATA on every cycle without a read.
  - Transitions: IDLE→CLEAR on clr_req; CLEAR→IDLE after the last address is written.
- Clear details:
  - On entry to CLEAR the FIFO is flushed and write_req pulses are ignored.
  - A clr_req during CLEAR restarts the sweep from 0.
  - Window set is still honoured during CLEAR.
- Asynchronous reset at any point aborts a clear or drain immediately; no partial-write guarantees.
- o_busy = (state==CLEAR) | ~fifo_empty.

Decomposition:
- Shared package spi2hdmi_pkg holds:
  - H_SIZE, V_SIZE, ADDR_W, CLR_DATA.
  - Window field bit-slice constants.
  - FSM state encoding.
- One natural sub-module: pix_wr_fifo.
  - Synchronous FIFO, width ADDR_W+16, depth FIFO_DEPTH.
  - Signals: push, pop, full, empty; flush input; async active-low reset.

Test Plan:
- Window set XS=2, XE=3, YS=1, YE=2, then 5 pixels A..E with no reads → SRAM writes at addresses 162, 163, 322, 323, then 162 (E wraps).
- i_rd_req held high during 6 pixel pulses with FIFO_DEPTH=4 → no writes, o_ovf pulses on the 5th and 6th pulses; release → exactly 4 writes in 4 consecutive cycles; o_busy falls after the last.
- clr_req → 20480 writes of 16'h0000 covering addresses 0..20479, o_busy high throughout; a read injected mid-clear gets o_rd_valid one cycle later and stretches the clear by one cycle.
- Window XS=158, XE=161, a row of 4 pixels → only x=158 and 159 are written; the cursor wraps to the next row correctly.
- waddr_set_req and write_req asserted in the same cycle → pixel written at (XS,YS).
- Reset asserted mid-clear → all outputs 0 asynchronously; after release, no writes occur until a new request.

Source files
------------

// File: rtl/spi2hdmi_pkg.sv
// Constants and types shared by the SPI-to-HDMI frame buffer blocks.
// Covers panel geometry, window field positions and the write scheduler state encoding.
package spi2hdmi_pkg;

    localparam int          H_SIZE   = 160;
    localparam int          V_SIZE   = 128;
    localparam int          ADDR_W   = 15;
    localparam logic [15:0] CLR_DATA = 16'h0000;

    // CASET/RASET words carry the start coordinate high and the end coordinate low
    localparam int WIN_START_MSB = 31;
    localparam int WIN_START_LSB = 16;
    localparam int WIN_END_MSB   = 15;
    localparam int WIN_END_LSB   = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } sched_state_e;

    function automatic logic [ADDR_W-1:0] row_base_of(input logic [15:0] y);
        return ADDR_W'(32'(y) * 32'(H_SIZE));
    endfunction

endpackage

// File: rtl/pix_wr_fifo.sv
// Small synchronous FIFO holding {address, pixel} writes while the scan-out reader owns the SRAM.
// Push when full and pop when empty are ignored; flush empties it in one cycle.
module pix_wr_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign o_rdata = mem_q[rd_ptr_q[PW-1:0]];

    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) mem_q[wr_ptr_q[PW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/sram_wr_sched.sv
// Schedules decoder pixel writes and frame clears onto the single SRAM port,
// giving the scan-out reader absolute priority and walking a CASET/RASET window cursor.
module sram_wr_sched
    import spi2hdmi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [15:0]       i_pixel_data,
    input  logic [31:0]       i_col_addr,
    input  logic [31:0]       i_row_addr,
    input  logic              i_sram_write_req,
    input  logic              i_sram_waddr_set_req,
    input  logic              i_sram_clr_req,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [15:0]       o_rd_data,
    output logic              o_rd_valid,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    input  logic [15:0]       i_mem_rdata,
    output logic              o_busy,
    output logic              o_ovf
);

    localparam int                FIFO_W    = ADDR_W + 16;
    localparam logic [15:0]       H_LIM     = 16'(H_SIZE);
    localparam logic [15:0]       V_LIM     = 16'(V_SIZE);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_SIZE * V_SIZE - 1);

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [15:0]       xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [15:0]       x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ovf_q, ovf_d;

    logic [15:0]       cur_x, cur_y;
    logic [ADDR_W-1:0] cur_base;
    logic              accept, in_range;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;

    // A window set in the same cycle as a pixel moves the cursor before the pixel is placed
    always_comb begin
        xs_d     = xs_q;
        xe_d     = xe_q;
        ys_d     = ys_q;
        ye_d     = ye_q;
        cur_x    = x_q;
        cur_y    = y_q;
        cur_base = row_base_q;
        if (i_sram_waddr_set_req) begin
            xs_d     = i_col_addr[WIN_START_MSB:WIN_START_LSB];
            xe_d     = i_col_addr[WIN_END_MSB:WIN_END_LSB];
            ys_d     = i_row_addr[WIN_START_MSB:WIN_START_LSB];
            ye_d     = i_row_addr[WIN_END_MSB:WIN_END_LSB];
            cur_x    = xs_d;
            cur_y    = ys_d;
            cur_base = row_base_of(ys_d);
        end

        accept     = i_sram_write_req & ~i_sram_clr_req & (state_q == ST_IDLE);
        in_range   = (cur_x < H_LIM) & (cur_y < V_LIM);
        fifo_push  = accept & in_range & ~fifo_full;
        ovf_d      = accept & in_range & fifo_full;
        fifo_wdata = {cur_base + ADDR_W'(cur_x), i_pixel_data};

        x_d        = cur_x;
        y_d        = cur_y;
        row_base_d = cur_base;
        // ">=" also covers inverted windows: the cursor then pins to the start coordinate
        if (accept) begin
            if (cur_x >= xe_d) begin
                x_d = xs_d;
                if (cur_y >= ye_d) begin
                    y_d        = ys_d;
                    row_base_d = row_base_of(ys_d);
                end else begin
                    y_d        = cur_y + 16'd1;
                    row_base_d = cur_base + ROW_STEP;
                end
            end else begin
                x_d = cur_x + 16'd1;
            end
        end
    end

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        fifo_pop    = 1'b0;
        if (i_rd_req) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_rd_addr;
        end else if (state_q == ST_CLEAR) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = clr_cnt_q;
            o_mem_wdata = CLR_DATA;
        end else if (!fifo_empty) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = fifo_rdata[FIFO_W-1:16];
            o_mem_wdata = fifo_rdata[15:0];
            fifo_pop    = 1'b1;
        end
    end

    // A clear request restarts the sweep; a read cycle stalls it without advancing
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rd_valid_d = i_rd_req;
        if (i_sram_clr_req) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
        end else if (state_q == ST_CLEAR && !i_rd_req) begin
            if (clr_cnt_q == LAST_ADDR) begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            xs_q       <= '0;
            xe_q       <= 16'(H_SIZE - 1);
            ys_q       <= '0;
            ye_q       <= 16'(V_SIZE - 1);
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            xs_q       <= xs_d;
            xe_q       <= xe_d;
            ys_q       <= ys_d;
            ye_q       <= ye_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_valid_q ? i_mem_rdata : 16'h0000;
    assign o_ovf      = ovf_q;
    assign o_busy     = (state_q == ST_CLEAR) | ~fifo_empty;

    pix_wr_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_wdata (fifo_wdata),
        .i_pop   (fifo_pop),
        .i_flush (i_sram_clr_req),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

endmodule

// File: tb/tb_sram_wr_sched.sv
// Randomised and directed bench for sram_wr_sched against a queue-based model of the port schedule.
module tb_sram_wr_sched;

   localparam int H     = 160;
   localparam int V     = 128;
   localparam int DEPTH = 4;
   localparam int TOTAL = H * V;

   logic        clk;
   logic        rst_n;
   logic [15:0] pixel_data;
   logic [31:0] col_addr, row_addr;
   logic        wr_req, set_req, clr_req, rd_req;
   logic [14:0] rd_addr;
   logic [15:0] rd_data;
   logic        rd_valid, mem_en, mem_we;
   logic [14:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        busy, ovf;

   int testsRun = 0;
   int testsFailed = 0;

   // model state
   int          mXs, mXe, mYs, mYe, mCx, mCy;
   bit          mClearing;
   int          mClrIdx;
   int          pendAddr[$];
   logic [15:0] pendData[$];
   bit          mRdPrev, mOvfNext;

   // observation logs for directed literal checks
   int wlog[$];
   int expLog[$];
   int ovfCnt;
   int busyCnt;

   sram_wr_sched #(.FIFO_DEPTH(DEPTH)) dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .i_pixel_data         (pixel_data),
      .i_col_addr           (col_addr),
      .i_row_addr           (row_addr),
      .i_sram_write_req     (wr_req),
      .i_sram_waddr_set_req (set_req),
      .i_sram_clr_req       (clr_req),
      .i_rd_req             (rd_req),
      .i_rd_addr            (rd_addr),
      .o_rd_data            (rd_data),
      .o_rd_valid           (rd_valid),
      .o_mem_en             (mem_en),
      .o_mem_we             (mem_we),
      .o_mem_addr           (mem_addr),
      .o_mem_wdata          (mem_wdata),
      .i_mem_rdata          (mem_rdata),
      .o_busy               (busy),
      .o_ovf                (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mXs = 0; mXe = H - 1; mYs = 0; mYe = V - 1;
      mCx = 0; mCy = 0;
      mClearing = 0; mClrIdx = 0;
      pendAddr.delete(); pendData.delete();
      mRdPrev = 0; mOvfNext = 0;
   endtask

   // Compare DUT outputs with the model, then advance the model by one clock
   always @(negedge clk) begin : compare
      bit          fullBefore, wasClearing, expEn, expWe;
      int          expAddr;
      logic [15:0] expData;
      if (!rst_n) begin
         checkOutput("rst_mem_en", mem_en, 0);
         checkOutput("rst_mem_we", mem_we, 0);
         checkOutput("rst_mem_addr", mem_addr, 0);
         checkOutput("rst_mem_wdata", mem_wdata, 0);
         checkOutput("rst_rd_valid", rd_valid, 0);
         checkOutput("rst_rd_data", rd_data, 0);
         checkOutput("rst_busy", busy, 0);
         checkOutput("rst_ovf", ovf, 0);
         modelReset();
      end else begin
         if (mem_en && mem_we) wlog.push_back(int'(mem_addr));
         if (ovf) ovfCnt++;
         if (busy) busyCnt++;

         fullBefore  = (pendAddr.size() == DEPTH);
         wasClearing = mClearing;
         expEn = 0; expWe = 0; expAddr = 0; expData = 16'h0000;
         if (rd_req) begin
            expEn = 1; expAddr = int'(rd_addr);
         end else if (mClearing) begin
            expEn = 1; expWe = 1; expAddr = mClrIdx; expData = 16'h0000;
         end else if (pendAddr.size() > 0) begin
            expEn = 1; expWe = 1; expAddr = pendAddr[0]; expData = pendData[0];
         end

         checkOutput("mem_en", mem_en, expEn);
         checkOutput("mem_we", mem_we, expWe);
         if (expEn) checkOutput("mem_addr", mem_addr, expAddr);
         if (expWe) checkOutput("mem_wdata", mem_wdata, expData);
         checkOutput("rd_valid", rd_valid, mRdPrev);
         if (mRdPrev) checkOutput("rd_data", rd_data, mem_rdata);
         checkOutput("busy", busy, (mClearing || pendAddr.size() > 0) ? 1 : 0);
         checkOutput("ovf", ovf, mOvfNext);

         if (!rd_req && !mClearing && pendAddr.size() > 0) begin
            void'(pendAddr.pop_front());
            void'(pendData.pop_front());
         end
         if (clr_req) begin
            mClearing = 1; mClrIdx = 0;
            pendAddr.delete(); pendData.delete();
         end else if (mClearing && !rd_req) begin
            if (mClrIdx == TOTAL - 1) mClearing = 0;
            else mClrIdx++;
         end
         if (set_req) begin
            mXs = int'(col_addr[31:16]); mXe = int'(col_addr[15:0]);
            mYs = int'(row_addr[31:16]); mYe = int'(row_addr[15:0]);
            mCx = mXs; mCy = mYs;
         end
         mOvfNext = 0;
         if (wr_req && !wasClearing && !clr_req) begin
            if (mCx < H && mCy < V) begin
               if (fullBefore) mOvfNext = 1;
               else begin
                  pendAddr.push_back(mCy * H + mCx);
                  pendData.push_back(pixel_data);
               end
            end
            if (mXs > mXe || mCx == mXe) begin
               mCx = mXs;
               if (mYs > mYe || mCy == mYe) mCy = mYs;
               else mCy++;
            end else begin
               mCx++;
            end
         end
         mRdPrev = rd_req;
      end
   end

   task automatic applyStimulus(input bit wr, input bit set, input bit clr, input bit rd,
                                input logic [15:0] data, input logic [31:0] col, input logic [31:0] row);
      @(posedge clk);
      #1;
      wr_req     = wr;
      set_req    = set;
      clr_req    = clr;
      rd_req     = rd;
      pixel_data = data;
      col_addr   = col;
      row_addr   = row;
      rd_addr    = 15'($urandom_range(0, 32767));
      mem_rdata  = 16'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, 0, 0, 0, 16'h0, 32'h0, 32'h0);
   endtask

   task automatic checkLog(input string name);
      checkOutput({name, "_count"}, wlog.size(), expLog.size());
      if (wlog.size() == expLog.size())
         for (int i = 0; i < expLog.size(); i++) checkOutput(name, wlog[i], expLog[i]);
   endtask

   task automatic waitIdle(input int bound);
      int n;
      n = 0;
      do begin
         applyStimulus(0, 0, 0, 0, 16'h0, 32'h0, 32'h0);
         @(negedge clk);
         n++;
      end while (busy && n < bound);
      if (busy) checkOutput("busy_timeout", 1, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      wr_req = 0; set_req = 0; clr_req = 0; rd_req = 0;
      pixel_data = 0; col_addr = 0; row_addr = 0; rd_addr = 0; mem_rdata = 0;
      ovfCnt = 0; busyCnt = 0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_mem_en", mem_en, 0);

      // Small window: E wraps back to the window origin
      wlog.delete();
      applyStimulus(0, 1, 0, 0, 16'h0, {16'd2, 16'd3}, {16'd1, 16'd2});
      applyStimulus(1, 0, 0, 0, 16'hA000, 32'h0, 32'h0);
      applyStimulus(1, 0, 0, 0, 16'hB000, 32'h0, 32'h0);
      applyStimulus(1, 0, 0, 0, 16'hC000, 32'h0, 32'h0);
      applyStimulus(1, 0, 0, 0, 16'hD000, 32'h0, 32'h0);
      applyStimulus(1, 0, 0, 0, 16'hE000, 32'h0, 32'h0);
      idle(4);
      expLog.delete();
      expLog.push_back(162); expLog.push_back(163); expLog.push_back(322);
      expLog.push_back(323); expLog.push_back(162);
      checkLog("win_small");

      // Reader holds the port through a 6-pixel burst
      applyStimulus(0, 1, 0, 0, 16'h0, {16'd0, 16'd159}, {16'd0, 16'd127});
      wlog.delete();
      ovfCnt = 0;
      repeat (6) applyStimulus(1, 0, 0, 1, 16'($urandom), 32'h0, 32'h0);
      idle(8);
      checkOutput("ovf_pulses", ovfCnt, 2);
      expLog.delete();
      for (int i = 0; i < 4; i++) expLog.push_back(i);
      checkLog("burst");
      checkOutput("burst_busy", busy, 0);

      // Full-frame clear with one read injected part way through
      wlog.delete();
      busyCnt = 0;
      applyStimulus(0, 0, 1, 0, 16'h0, 32'h0, 32'h0);
      idle(100);
      applyStimulus(0, 0, 0, 1, 16'h0, 32'h0, 32'h0);
      waitIdle(25000);
      checkOutput("clr_writes", wlog.size(), TOTAL);
      if (wlog.size() == TOTAL) begin
         checkOutput("clr_first", wlog[0], 0);
         checkOutput("clr_last", wlog[TOTAL-1], TOTAL - 1);
      end
      checkOutput("clr_busy_cycles", busyCnt, TOTAL + 1);

      // Window straddling the right edge
      wlog.delete();
      applyStimulus(0, 1, 0, 0, 16'h0, {16'd158, 16'd161}, {16'd5, 16'd6});
      repeat (6) applyStimulus(1, 0, 0, 0, 16'($urandom), 32'h0, 32'h0);
      idle(4);
      expLog.delete();
      expLog.push_back(958); expLog.push_back(959);
      expLog.push_back(1118); expLog.push_back(1119);
      checkLog("edge");

      // Window set together with a pixel
      wlog.delete();
      applyStimulus(1, 1, 0, 0, 16'h1234, {16'd10, 16'd20}, {16'd3, 16'd4});
      applyStimulus(1, 0, 0, 0, 16'h5678, 32'h0, 32'h0);
      idle(4);
      expLog.delete();
      expLog.push_back(490); expLog.push_back(491);
      checkLog("set_wr");

      // Random traffic, read-heavy first half to exercise overflow
      for (int i = 0; i < 1500; i++) begin
         bit rw, rs, rr;
         rw = bit'($urandom % 2);
         rs = ($urandom % 40) == 0;
         rr = (i < 750) ? (($urandom % 10) < 7) : (($urandom % 4) == 0);
         applyStimulus(rw, rs, 0, rr, 16'($urandom),
                       {16'($urandom_range(0, 170)), 16'($urandom_range(0, 170))},
                       {16'($urandom_range(0, 135)), 16'($urandom_range(0, 135))});
      end
      idle(10);

      // Clear restart, ignored pixels and a window set during clear, then reset mid-clear
      applyStimulus(0, 0, 1, 0, 16'h0, 32'h0, 32'h0);
      idle(30);
      applyStimulus(0, 0, 1, 0, 16'h0, 32'h0, 32'h0);
      applyStimulus(1, 0, 0, 0, 16'hFFFF, 32'h0, 32'h0);
      applyStimulus(1, 1, 0, 0, 16'hFFFF, {16'd4, 16'd8}, {16'd4, 16'd8});
      idle(30);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("async_mem_en", mem_en, 0);
      checkOutput("async_mem_we", mem_we, 0);
      checkOutput("async_busy", busy, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      wlog.delete();
      idle(20);
      checkOutput("post_reset_writes", wlog.size(), 0);
      checkOutput("post_reset_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
